// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word/block sizes, FSM states,
// the round-constant table and the small-sigma functions.
package sha256_pkg;

  localparam int WRD_SIZE     = 32;
  localparam int MSG_BLK_SIZE = 512;
  localparam int NUM_ROUNDS   = 64;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational SHA-256 round-constant lookup: 6-bit round index to K[t].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K_TABLE[idx];

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: accepts a 512-bit block and streams W[0..63] with
// valid/ready flow control. Define MSG_SCHED_KROM_EN to emit K[t] alongside W[t].
module msg_schedule #(
  parameter int WRD_SIZE     = sha256_pkg::WRD_SIZE,
  parameter int MSG_BLK_SIZE = sha256_pkg::MSG_BLK_SIZE,
  parameter int NUM_ROUNDS   = sha256_pkg::NUM_ROUNDS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_blk_valid,
  output logic                    o_blk_ready,
  input  logic [MSG_BLK_SIZE-1:0] i_msg_blk,
  output logic                    o_w_valid,
  input  logic                    i_w_ready,
  output logic [WRD_SIZE-1:0]     o_w,
  output logic [5:0]              o_round_idx,
  output logic [WRD_SIZE-1:0]     o_round_constant,
  output logic                    o_last
);
  import sha256_pkg::*;

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  state_t                     state;
  logic [5:0]                 t;
  logic [15:0][WRD_SIZE-1:0]  window;
  logic [WRD_SIZE-1:0]        next_w;
  logic                       run;

  assign run    = (state == RUN);
  assign next_w = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      t      <= '0;
      window <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_blk_valid) begin
            for (int unsigned i = 0; i < 16; i++)
              window[i] <= i_msg_blk[MSG_BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
            t     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (i_w_ready) begin
            // window[0] is always W[t]; the new tail is W[t+16]
            for (int unsigned i = 0; i < 15; i++)
              window[i] <= window[i+1];
            window[15] <= next_w;
            t          <= t + 6'd1;
            if (t == LAST_T)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_blk_ready = (state == IDLE);
  assign o_w_valid   = run;
  assign o_w         = run ? window[0] : '0;
  assign o_round_idx = run ? t : '0;
  assign o_last      = run && (t == LAST_T);

`ifdef MSG_SCHED_KROM_EN
  logic [31:0] k_val;

  sha256_k_rom u_k_rom (
    .idx (t),
    .k   (k_val)
  );

  assign o_round_constant = run ? k_val : '0;
`else
  assign o_round_constant = '0;
`endif

endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 The block SHALL have parameter WRD_SIZE, default 32, giving the schedule word width.
REQ-002 The block SHALL have parameter MSG_BLK_SIZE, default 512, giving the message block width (16 words).
REQ-003 The block SHALL have parameter NUM_ROUNDS, default 64, giving the number of schedule words per block.
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 `clk`  input  1  is the sole clock; all state updates on its rising edge.
REQ-006 `reset`  input  1  is the asynchronous, active-high reset.
REQ-007 `i_blk_valid`  input  1  indicates that a message block is offered.
REQ-008 `o_blk_ready`  output  1  indicates that the block can accept a new message block.
REQ-009 `i_msg_blk`  input  MSG_BLK_SIZE  is the message block; word 0 is [511:480] and word 15 is [31:0].
REQ-010 `o_w_valid`  output  1  indicates that schedule word W[t] is valid.
REQ-011 `i_w_ready`  input  1  indicates that the round datapath consumes W[t].
REQ-012 `o_w`  output  WRD_SIZE  carries the schedule word W[t].
REQ-013 `o_round_idx`  output  6  carries the round index t (0..63).
REQ-014 `o_round_constant`  output  WRD_SIZE  carries the round constant K[t].
REQ-015 `o_last`  output  1  is high when t==NUM_ROUNDS-1.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-017 o_blk_ready SHALL be 1 if and only if the state is IDLE.
REQ-018 When i_blk_valid & o_blk_ready is high (block handshake), the block SHALL load the 16 words into window[0..15], set t=0, and enter RUN.
REQ-019 The first word SHALL be valid on the cycle after the block handshake (latency 1).
REQ-020 In RUN, o_w_valid SHALL be 1, o_w SHALL equal window[0] (= W[t]), and o_round_idx SHALL equal t.
REQ-021 When o_w_valid & i_w_ready is high (word handshake), the window SHALL shift down by one, t SHALL increment, and window[15] SHALL receive W[t+16] = σ1(window[14]) + window[9] + σ0(window[1]) + window[0], summed mod 2^32.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
REQ-022 When o_w_valid is high and i_w_ready is low (stall), o_w, o_round_idx, o_round_constant and o_last SHALL hold stable, with no skipped or duplicated words.
REQ-023 With i_w_ready held high, the block SHALL deliver one word per cycle (64 words in 64 consecutive cycles).
REQ-024 A word handshake while o_last is high SHALL return the FSM to IDLE, with o_w_valid going to 0 on the next cycle.
REQ-025 A new block SHALL NOT be accepted in the same cycle as the last word handshake.
REQ-026 In RUN, i_blk_valid SHALL be ignored.
REQ-027 In IDLE, i_w_ready SHALL be ignored.

Reset
REQ-028 While reset is asserted, the block SHALL be in state IDLE with o_w_valid=0, o_w=0, o_round_idx=0, o_last=0, o_round_constant=0 and o_blk_ready=1.
REQ-029 While reset is asserted, the block SHALL NOT accept any block.
REQ-030 Reset asserted mid-RUN SHALL abort the block immediately; a subsequent block SHALL restart at t=0.

Configuration
REQ-031 With macro MSG_SCHED_KROM_EN defined, o_round_constant SHALL equal K[t] from the SHA-256 constant table (K[0]=428a2f98, K[63]=c67178f2), aligned with o_w.
REQ-032 Without MSG_SCHED_KROM_EN, o_round_constant SHALL be tied to 0, no constant table SHALL be synthesized, and the K value SHALL be supplied externally.

Structure
REQ-033 Shared package sha256_pkg SHALL hold WRD_SIZE, MSG_BLK_SIZE, NUM_ROUNDS, the 64-entry K table, and the σ0/σ1 functions.
REQ-034 One sub-module, sha256_k_rom (6-bit index to 32-bit K, combinational), SHALL exist and SHALL be instantiated only under MSG_SCHED_KROM_EN.

Verification
REQ-035 "abc" padded block (61626380, 14×00000000, 00000018) with ready=1 -> W0=61626380, W15=00000018, W16=61626380, W17=000F0000; o_last high only at t=63; 64 words in 64 cycles.
REQ-036 Same block with i_w_ready low for 3 cycles at t=16 -> o_w holds 61626380 and o_round_idx holds 16; next word W17=000F0000.
REQ-037 i_blk_valid held high throughout -> second block accepted on the first cycle after the t=63 handshake+1; first block's words are unaffected.
REQ-038 Reset pulsed at t=30 -> outputs 0 and o_blk_ready=1; a new block restarts at t=0 with correct W0.
REQ-039 All-ones block -> W16=203FFFFC (mod-2^32 wrap check).
REQ-040 With MSG_SCHED_KROM_EN, o_round_constant SHALL read 428a2f98 at t=0 and c67178f2 at t=63; without the macro, it SHALL read 0 for all t.
